// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the AlphaOne RV32I core.
//
// Captures the decoded control bundle from the controller together with the
// decode-stage operands into the EX-stage register. A load in EX whose
// destination is read by the instruction in ID raises stallOut and loads a
// bubble into EX. An EX-stage redirect squashes the instruction being
// captured. Two saturating counters record stall and flush events.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 decode stage holds a valid instruction
//   id_pc/rs1Data/rs2Data/imm  decode-stage data (XLEN bits each)
//   id_rs1/rs2/rd            register indices
//   id_usesRs1/usesRs2       instruction actually reads rs1/rs2
//   id_<ctrl>                controller outputs
//   ex_redirect              EX resolved a taken branch/jump
//   stallOut                 hold PC and IF/ID this cycle (combinational)
//   ex_valid, ex_*           registered EX-stage copies
//   stallCnt, flushCnt       saturating event counters (CNTW bits)
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1Data,
    input  logic [XLEN-1:0] id_rs2Data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_usesRs1,
    input  logic            id_usesRs2,
    input  logic            id_regWR,
    input  logic            id_memWR,
    input  logic            id_aluS1,
    input  logic            id_aluS2,
    input  logic            id_doBranch,
    input  logic            id_doJump,
    input  logic [1:0]      id_wbCtrl,
    input  logic [3:0]      id_aluOp,
    input  logic [2:0]      id_branchCtrl,
    input  logic [2:0]      id_memCtrl,
    input  logic            ex_redirect,
    output logic            stallOut,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1Data,
    output logic [XLEN-1:0] ex_rs2Data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_regWR,
    output logic            ex_memWR,
    output logic            ex_aluS1,
    output logic            ex_aluS2,
    output logic            ex_doBranch,
    output logic            ex_doJump,
    output logic [1:0]      ex_wbCtrl,
    output logic [3:0]      ex_aluOp,
    output logic [2:0]      ex_branchCtrl,
    output logic [2:0]      ex_memCtrl,
    output logic [CNTW-1:0] stallCnt,
    output logic [CNTW-1:0] flushCnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1Data;
        logic [XLEN-1:0] rs2Data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regWR;
        logic            memWR;
        logic            aluS1;
        logic            aluS2;
        logic            doBranch;
        logic            doJump;
        logic [1:0]      wbCtrl;
        logic [3:0]      aluOp;
        logic [2:0]      branchCtrl;
        logic [2:0]      memCtrl;
    } ex_reg_t;

    localparam ex_reg_t       BUBBLE   = '0;
    localparam logic [1:0]    WB_MEM   = 2'b01;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    ex_reg_t         ex_q, ex_d, cap_s;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
    logic            load_in_ex_s;
    logic            hazard_s;

    // Load-use hazard detection against the instruction currently in EX.
    always_comb begin
        load_in_ex_s = ex_q.valid & (ex_q.wbCtrl == WB_MEM);
        hazard_s     = load_in_ex_s & (ex_q.rd != 5'd0) & id_valid &
                       ((id_usesRs1 & (id_rs1 == ex_q.rd)) |
                        (id_usesRs2 & (id_rs2 == ex_q.rd)));
    end

    // A redirect kills the ID instruction anyway, so it must not stall fetch.
    assign stallOut = hazard_s & ~ex_redirect;

    // Normal capture; side-effecting controls are gated by id_valid, and
    // writes to x0 are dropped here so EX/WB never see them.
    always_comb begin
        cap_s            = BUBBLE;
        cap_s.valid      = id_valid;
        cap_s.pc         = id_pc;
        cap_s.rs1Data    = id_rs1Data;
        cap_s.rs2Data    = id_rs2Data;
        cap_s.imm        = id_imm;
        cap_s.rs1        = id_rs1;
        cap_s.rs2        = id_rs2;
        cap_s.rd         = id_rd;
        cap_s.regWR      = id_regWR & id_valid & (id_rd != 5'd0);
        cap_s.memWR      = id_memWR & id_valid;
        cap_s.aluS1      = id_aluS1;
        cap_s.aluS2      = id_aluS2;
        cap_s.doBranch   = id_doBranch & id_valid;
        cap_s.doJump     = id_doJump & id_valid;
        cap_s.wbCtrl     = id_wbCtrl;
        cap_s.aluOp      = id_aluOp;
        cap_s.branchCtrl = id_branchCtrl;
        cap_s.memCtrl    = id_memCtrl;
    end

    // Next-state selection: flush beats stall beats capture.
    always_comb begin
        ex_d        = cap_s;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect) begin
            ex_d        = BUBBLE;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hazard_s) begin
            ex_d        = BUBBLE;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ex_d = cap_s;
        end
    end

    // EX-stage register and event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1Data    = ex_q.rs1Data;
    assign ex_rs2Data    = ex_q.rs2Data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_regWR      = ex_q.regWR;
    assign ex_memWR      = ex_q.memWR;
    assign ex_aluS1      = ex_q.aluS1;
    assign ex_aluS2      = ex_q.aluS2;
    assign ex_doBranch   = ex_q.doBranch;
    assign ex_doJump     = ex_q.doJump;
    assign ex_wbCtrl     = ex_q.wbCtrl;
    assign ex_aluOp      = ex_q.aluOp;
    assign ex_branchCtrl = ex_q.branchCtrl;
    assign ex_memCtrl    = ex_q.memCtrl;
    assign stallCnt      = stall_cnt_q;
    assign flushCnt      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed testbench for id_ex_stage. A second instance with 4-bit counters
// shares all inputs and is used to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1Data, id_rs2Data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_usesRs1, id_usesRs2;
    logic        id_regWR, id_memWR, id_aluS1, id_aluS2, id_doBranch, id_doJump;
    logic [1:0]  id_wbCtrl;
    logic [3:0]  id_aluOp;
    logic [2:0]  id_branchCtrl, id_memCtrl;
    logic        ex_redirect;

    logic        stallOut, ex_valid;
    logic [31:0] ex_pc, ex_rs1Data, ex_rs2Data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regWR, ex_memWR, ex_aluS1, ex_aluS2, ex_doBranch, ex_doJump;
    logic [1:0]  ex_wbCtrl;
    logic [3:0]  ex_aluOp;
    logic [2:0]  ex_branchCtrl, ex_memCtrl;
    logic [15:0] stallCnt, flushCnt;

    logic        s_stallOut, s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_rs1Data, s_ex_rs2Data, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic        s_ex_regWR, s_ex_memWR, s_ex_aluS1, s_ex_aluS2, s_ex_doBranch, s_ex_doJump;
    logic [1:0]  s_ex_wbCtrl;
    logic [3:0]  s_ex_aluOp;
    logic [2:0]  s_ex_branchCtrl, s_ex_memCtrl;
    logic [3:0]  s_stallCnt, s_flushCnt;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int exp_small = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_usesRs1(id_usesRs1), .id_usesRs2(id_usesRs2),
        .id_regWR(id_regWR), .id_memWR(id_memWR), .id_aluS1(id_aluS1), .id_aluS2(id_aluS2),
        .id_doBranch(id_doBranch), .id_doJump(id_doJump), .id_wbCtrl(id_wbCtrl),
        .id_aluOp(id_aluOp), .id_branchCtrl(id_branchCtrl), .id_memCtrl(id_memCtrl),
        .ex_redirect(ex_redirect), .stallOut(stallOut), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regWR(ex_regWR), .ex_memWR(ex_memWR), .ex_aluS1(ex_aluS1), .ex_aluS2(ex_aluS2),
        .ex_doBranch(ex_doBranch), .ex_doJump(ex_doJump), .ex_wbCtrl(ex_wbCtrl),
        .ex_aluOp(ex_aluOp), .ex_branchCtrl(ex_branchCtrl), .ex_memCtrl(ex_memCtrl),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    id_ex_stage #(.XLEN(32), .CNTW(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_usesRs1(id_usesRs1), .id_usesRs2(id_usesRs2),
        .id_regWR(id_regWR), .id_memWR(id_memWR), .id_aluS1(id_aluS1), .id_aluS2(id_aluS2),
        .id_doBranch(id_doBranch), .id_doJump(id_doJump), .id_wbCtrl(id_wbCtrl),
        .id_aluOp(id_aluOp), .id_branchCtrl(id_branchCtrl), .id_memCtrl(id_memCtrl),
        .ex_redirect(ex_redirect), .stallOut(s_stallOut), .ex_valid(s_ex_valid),
        .ex_pc(s_ex_pc), .ex_rs1Data(s_ex_rs1Data), .ex_rs2Data(s_ex_rs2Data), .ex_imm(s_ex_imm),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_regWR(s_ex_regWR), .ex_memWR(s_ex_memWR), .ex_aluS1(s_ex_aluS1), .ex_aluS2(s_ex_aluS2),
        .ex_doBranch(s_ex_doBranch), .ex_doJump(s_ex_doJump), .ex_wbCtrl(s_ex_wbCtrl),
        .ex_aluOp(s_ex_aluOp), .ex_branchCtrl(s_ex_branchCtrl), .ex_memCtrl(s_ex_memCtrl),
        .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction onto the ID inputs.
    task automatic drive_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                               input logic u2, input logic rw, input logic mw, input logic [1:0] wb);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_usesRs1 = u1; id_usesRs2 = u2; id_regWR = rw; id_memWR = mw; id_wbCtrl = wb;
        id_rs1Data = 32'hAAAA_0001; id_rs2Data = 32'hBBBB_0002; id_imm = 32'h0000_0010;
        id_aluS1 = 1'b0; id_aluS2 = 1'b1; id_doBranch = 1'b0; id_doJump = 1'b0;
        id_aluOp = 4'b0000; id_branchCtrl = 3'b000; id_memCtrl = 3'b010;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_redirect = 1'b0;
        id_valid = 1'b1; id_pc = $urandom(); id_rs1Data = $urandom(); id_rs2Data = $urandom();
        id_imm = $urandom(); id_rs1 = 5'd7; id_rs2 = 5'd7; id_rd = 5'd7;
        id_usesRs1 = 1'b1; id_usesRs2 = 1'b1; id_regWR = 1'b1; id_memWR = 1'b1;
        id_aluS1 = 1'b1; id_aluS2 = 1'b1; id_doBranch = 1'b1; id_doJump = 1'b1;
        id_wbCtrl = 2'b01; id_aluOp = 4'hF; id_branchCtrl = 3'h7; id_memCtrl = 3'h7;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %0b want 0", ex_valid); end
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL rst_stall1: got %0b want 0", stallOut); end
        tick();
        checks++; if (ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_imm !== 32'h0) begin
            errors++; $display("FAIL rst_data: pc=%h rd=%0d imm=%h want 0", ex_pc, ex_rd, ex_imm); end
        checks++; if (ex_regWR !== 1'b0 || ex_memWR !== 1'b0 || ex_wbCtrl !== 2'b00 || ex_aluOp !== 4'h0) begin
            errors++; $display("FAIL rst_ctrl: regWR=%0b memWR=%0b wb=%0b op=%0h want 0", ex_regWR, ex_memWR, ex_wbCtrl, ex_aluOp); end
        checks++; if (stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt: stall=%0d flush=%0d want 0", stallCnt, flushCnt); end
        rst = 1'b0;
        drive_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_pass_through();
        drive_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        id_aluOp = 4'b0010; id_doJump = 1'b1;
        tick();
        checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL pass_pc: got %h want 100", ex_pc); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL pass_rd: got %0d want 5", ex_rd); end
        checks++; if (ex_aluOp !== 4'b0010) begin errors++; $display("FAIL pass_aluop: got %0h want 2", ex_aluOp); end
        checks++; if (ex_regWR !== 1'b1 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL pass_valid: regWR=%0b valid=%0b want 1 1", ex_regWR, ex_valid); end
        checks++; if (ex_memWR !== 1'b1 || ex_doJump !== 1'b1 || ex_rs1Data !== 32'hAAAA_0001) begin
            errors++; $display("FAIL pass_ctrl: memWR=%0b doJump=%0b rs1Data=%h", ex_memWR, ex_doJump, ex_rs1Data); end
        // Invalid instruction: side effects gated, data passes through.
        drive_instr(1'b0, 32'h200, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        id_doBranch = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_regWR !== 1'b0 || ex_memWR !== 1'b0 || ex_doBranch !== 1'b0) begin
            errors++; $display("FAIL inval_gate: valid=%0b regWR=%0b memWR=%0b br=%0b want 0", ex_valid, ex_regWR, ex_memWR, ex_doBranch); end
        checks++; if (ex_pc !== 32'h200) begin errors++; $display("FAIL inval_pc: got %h want 200", ex_pc); end
    endtask

    task automatic test_load_use();
        drive_instr(1'b1, 32'h2F0, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        tick();
        drive_instr(1'b1, 32'h300, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stallOut); end
        tick(); exp_stall++; exp_small++;
        checks++; if (ex_valid !== 1'b0 || ex_regWR !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: valid=%0b regWR=%0b want 0 0", ex_valid, ex_regWR); end
        checks++; if (stallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stallCnt, exp_stall); end
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stallOut); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_rd !== 5'd8) begin
            errors++; $display("FAIL lu_capture: valid=%0b pc=%h rd=%0d want 1 300 8", ex_valid, ex_pc, ex_rd); end
    endtask

    task automatic test_back_to_back();
        drive_instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL b2b_nostall: got %0b want 0", stallOut); end
        tick();
        drive_instr(1'b1, 32'h404, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL b2b_stallB: got %0b want 1", stallOut); end
        tick(); exp_stall++; exp_small++;
        tick();
        checks++; if (ex_rd !== 5'd10 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_capB: rd=%0d valid=%0b want 10 1", ex_rd, ex_valid); end
        drive_instr(1'b1, 32'h408, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL b2b_stallC: got %0b want 1", stallOut); end
        tick(); exp_stall++; exp_small++;
        tick();
        checks++; if (ex_rd !== 5'd11 || stallCnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL b2b_capC: rd=%0d cnt=%0d want 11 %0d", ex_rd, stallCnt, exp_stall); end
    endtask

    task automatic test_x0_unused();
        drive_instr(1'b1, 32'h500, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        tick();
        checks++; if (ex_regWR !== 1'b0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL x0_regwr: regWR=%0b valid=%0b want 0 1", ex_regWR, ex_valid); end
        drive_instr(1'b1, 32'h504, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL x0_nostall: got %0b want 0", stallOut); end
        drive_instr(1'b1, 32'h508, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        tick();
        drive_instr(1'b1, 32'h50C, 5'd7, 5'd7, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL unused_nostall: got %0b want 0", stallOut); end
        drive_instr(1'b0, 32'h50C, 5'd7, 5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL invalid_nostall: got %0b want 0", stallOut); end
    endtask

    task automatic test_flush_vs_stall();
        // EX still holds the load to x7 from the previous scenario.
        drive_instr(1'b1, 32'h600, 5'd7, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        ex_redirect = 1'b1; #1;
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", stallOut); end
        tick(); exp_flush++;
        ex_redirect = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_memWR !== 1'b0 || ex_pc !== 32'h0) begin
            errors++; $display("FAIL flush_bubble: valid=%0b memWR=%0b pc=%h want 0 0 0", ex_valid, ex_memWR, ex_pc); end
        checks++; if (flushCnt !== 16'(exp_flush) || stallCnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL flush_cnt: flush=%0d stall=%0d want %0d %0d", flushCnt, stallCnt, exp_flush, exp_stall); end
        // Plain redirect of a live instruction with no hazard.
        drive_instr(1'b1, 32'h700, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        ex_redirect = 1'b1;
        tick(); exp_flush++;
        ex_redirect = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || flushCnt !== 16'(exp_flush)) begin
            errors++; $display("FAIL flush_plain: valid=%0b rd=%0d flush=%0d want 0 0 %0d", ex_valid, ex_rd, flushCnt, exp_flush); end
        checks++; if (s_flushCnt !== 4'(exp_flush)) begin
            errors++; $display("FAIL flush_small: got %0d want %0d", s_flushCnt, exp_flush); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive_instr(1'b1, 32'h800, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
            tick();
            drive_instr(1'b1, 32'h804, 5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
            tick();
            exp_stall++;
            if (exp_small < 15) exp_small++;
            checks++; if (s_stallCnt !== 4'(exp_small) || stallCnt !== 16'(exp_stall)) begin
                errors++; $display("FAIL sat_iter%0d: small=%0d main=%0d want %0d %0d", i, s_stallCnt, stallCnt, exp_small, exp_stall); end
        end
        checks++; if (s_stallCnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", s_stallCnt); end
    endtask

    task automatic test_reset_mid_flush();
        drive_instr(1'b1, 32'h900, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        tick();
        drive_instr(1'b1, 32'h904, 5'd7, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        ex_redirect = 1'b1; rst = 1'b1;
        tick();
        ex_redirect = 1'b0; rst = 1'b0;
        checks++; if (ex_valid !== 1'b0 || stallCnt !== 16'd0 || flushCnt !== 16'd0 || s_stallCnt !== 4'd0) begin
            errors++; $display("FAIL rst_mid: valid=%0b stall=%0d flush=%0d small=%0d want 0", ex_valid, stallCnt, flushCnt, s_stallCnt); end
        checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0b want 0", stallOut); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_back_to_back();
        test_x0_unused();
        test_flush_vs_stall();
        test_saturation();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
